// File: rtl/toad_move_ctrl.sv
// Toad movement controller: turns held direction buttons into cell-by-cell
// moves through a maze. Each move reads the target cell from a
// synchronous maze RAM and then commits or rejects it.
module toad_move_ctrl #(
  parameter logic [7:0]  START_X    = 8'd2,
  parameter logic [7:0]  START_Y    = 8'd2,
  parameter int unsigned STEP_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        restart,
  output logic [13:0] map_addr,
  input  logic [1:0]  map_data,
  output logic [7:0]  locX,
  output logic [7:0]  locY,
  output logic        busy,
  output logic        hit_wall,
  output logic        at_goal
);

  localparam int unsigned     CW       = $clog2(STEP_TICKS) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(STEP_TICKS - 1);
  localparam logic [7:0]      COORD_LO = 8'd2;
  localparam logic [7:0]      COORD_HI = 8'd125;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   step_cnt;
  logic [CW-1:0]   step_cnt_inc;
  logic [7:0]      tgt_x;
  logic [7:0]      tgt_y;
  logic [7:0]      cand_x;
  logic [7:0]      cand_y;
  logic            any_btn;
  logic            cand_ok;
  logic            launch;
  logic            go;

  // Candidate target from the highest-priority held button
  always_comb begin
    cand_x  = locX;
    cand_y  = locY;
    any_btn = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)         cand_y = locY - 8'd1;
    else if (btn_down)  cand_y = locY + 8'd1;
    else if (btn_left)  cand_x = locX - 8'd1;
    else if (btn_right) cand_x = locX + 8'd1;
    cand_ok = (cand_x >= COORD_LO) && (cand_x <= COORD_HI) &&
              (cand_y >= COORD_LO) && (cand_y <= COORD_HI);
  end

  // Launch decision and modulo step-counter increment
  always_comb begin
    step_cnt_inc = (step_cnt == CNT_LAST) ? '0 : step_cnt + CW'(1);
    // Once the goal is reached, launches are suppressed entirely so that
    // no RAM access and no hit_wall pulse occur.
    launch = (state == S_IDLE) && tick && any_btn && (step_cnt == '0) &&
             !at_goal && !restart;
    go     = launch && cand_ok;
  end

  // Next-state logic: a launched move walks REQ -> WAIT -> CHECK -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset beats restart, restart beats everything else
  always_ff @(posedge clk) begin
    if (reset || restart) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  // Datapath: step counter, target latch, RAM address, position and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
      tgt_x    <= START_X;
      tgt_y    <= START_Y;
      map_addr <= '0;
      locX     <= START_X;
      locY     <= START_Y;
      hit_wall <= 1'b0;
      at_goal  <= 1'b0;
    end else if (restart) begin
      step_cnt <= '0;
      locX     <= START_X;
      locY     <= START_Y;
      hit_wall <= 1'b0;
      at_goal  <= 1'b0;
    end else begin
      hit_wall <= 1'b0;

      if (!any_btn)
        step_cnt <= '0;
      else if (tick && (state == S_IDLE))
        step_cnt <= step_cnt_inc;

      if (launch) begin
        tgt_x <= cand_x;
        tgt_y <= cand_y;
        if (!cand_ok) hit_wall <= 1'b1;
      end

      if (state == S_REQ)
        map_addr <= {tgt_y[6:0], tgt_x[6:0]};

      if (state == S_CHECK) begin
        case (map_data)
          2'd0: begin
            locX <= tgt_x;
            locY <= tgt_y;
          end
          2'd2: begin
            locX    <= tgt_x;
            locY    <= tgt_y;
            at_goal <= 1'b1;
          end
          default: hit_wall <= 1'b1;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/toad_move_ctrl.md
TOAD_MOVE_CTRL -- requirements
Module: toad_move_ctrl

Interface
REQ-001 Parameter START_X, default 8'd2, toad column at reset/restart (maze cell units).
REQ-002 Parameter START_Y, default 8'd2, toad row at reset/restart.
REQ-003 Parameter STEP_TICKS, default 4, ticks between repeated moves while a button is held (>=1).
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  one-cycle move-rate strobe.
REQ-007 btn_up, btn_down, btn_left, btn_right  input  1 each  debounced level buttons.
REQ-008 restart  input  1  one-cycle strobe; return toad to start.
REQ-009 map_addr  output  14  maze RAM read address {row[6:0], col[6:0]}, registered.
REQ-010 map_data  input  2  maze cell code, valid exactly 1 cycle after map_addr changes.
REQ-011 locX, locY  output  8 each  toad cell position; feeds the icon renderer.
REQ-012 busy  output  1  high whenever FSM is not IDLE.
REQ-013 hit_wall  output  1  one-cycle pulse on a rejected move.
REQ-014 at_goal  output  1  sticky goal-reached flag.

Function
REQ-015 Cell codes SHALL be: 0 floor, 1 wall, 2 goal, 3 treated as wall.
REQ-016 Direction priority SHALL be up > down > left > right; one direction per move; up = locY-1, down = locY+1, left = locX-1, right = locX+1.
REQ-017 Step counter (width ceil(log2(STEP_TICKS))+1) SHALL clear whenever no button is held.
REQ-018 In IDLE, a tick with a button held and counter==0 SHALL launch a move; every tick with a button held SHALL advance counter modulo STEP_TICKS.
REQ-019 Ticks arriving while busy SHALL be ignored (no launch, no counter advance).
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, CHECK; launch: IDLE->REQ, then REQ->WAIT->CHECK->IDLE unconditionally, one cycle each.
REQ-021 At launch, target (tgtX,tgtY) SHALL be latched; if any target coordinate lies outside [2,125], FSM SHALL stay in IDLE and hit_wall SHALL pulse next cycle.
REQ-022 In REQ, map_addr SHALL be loaded with {tgtY[6:0], tgtX[6:0]}; map_addr SHALL hold its value otherwise.
REQ-023 In CHECK, map_data SHALL be sampled: floor -> locX/locY <= target; goal -> locX/locY <= target and at_goal <= 1; wall/3 -> position unchanged, hit_wall pulses one cycle.
REQ-024 Position updates SHALL be visible on locX/locY the cycle after CHECK; move latency launch-tick to new position = 4 cycles.
REQ-025 After at_goal is set, further moves SHALL be rejected silently (no hit_wall) until restart or reset.
REQ-026 restart SHALL, in any state, force IDLE, locX<=START_X, locY<=START_Y, at_goal<=0, counter<=0, next cycle; restart wins over a simultaneous tick.
REQ-027 busy SHALL be a combinational decode of state != IDLE.

Reset
REQ-028 On reset (any state, including mid-move): state IDLE, locX=START_X, locY=START_Y, map_addr=0, counter=0, hit_wall=0, at_goal=0, busy=0.
REQ-029 reset SHALL take precedence over restart, tick and all buttons.

Verification
REQ-030 Reset, map all floor, btn_right held, tick at cycle 10 -> busy 11..13, locX=3 at cycle 14, locY=2; map_addr=14'h0103 during WAIT.
REQ-031 btn_right held, STEP_TICKS=4, 9 ticks spaced 8 cycles apart -> exactly 3 moves (ticks 1,5,9), locX=5.
REQ-032 Cell (2,3) = wall, btn_down pressed + tick -> locY stays 2, hit_wall high exactly 1 cycle after CHECK.
REQ-033 At locX=2, btn_left + tick -> no RAM access, busy stays 0, hit_wall pulses once; btn_up+btn_left simultaneously at (2,5) -> moves up to (2,4).
REQ-034 Cell (3,2) = goal, move right -> locX=3, at_goal=1; next right move -> no change, no hit_wall; restart -> (2,2), at_goal=0.
REQ-035 reset asserted during WAIT -> next cycle IDLE, position (2,2), no update from the pending map_data.
